branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/riscv_branch_pkg.sv | 13 +
 rtl/branch_bht.sv | 25 ++
 rtl/branch_resolve_unit.sv | 76 +++++++
 tb/tb_branch_resolve_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// riscv_branch_pkg: branch funct3 encodings and BHT counter types
package riscv_branch_pkg;
  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_type_e;
  typedef logic [1:0] bht_cnt_t;
  localparam bht_cnt_t BHT_RESET_VAL = 2'b01;
endpackage

// File: rtl/branch_bht.sv
// branch_bht: table of 2-bit saturating counters; reads return the value before any same-edge update
module branch_bht import riscv_branch_pkg::*; #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  bht_cnt_t cnt [2**IDX_W];
  bht_cnt_t cur;
  assign rd_taken = cnt[rd_idx][1];
  assign cur = cnt[wr_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= BHT_RESET_VAL;
    end else if (wr_en) begin
      cnt[wr_idx] <= wr_taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                              : ((cur == 2'b00) ? cur : cur - 2'd1);
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX conditional branches with a 1-cycle registered result and statistics.
// Define BRANCH_RESOLVE_BHT_EN to add the branch history table predictor.
module branch_resolve_unit import riscv_branch_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [2:0]      ex_branch_type,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic            flush,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            res_illegal,
  output logic [XLEN-1:0] res_redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  logic fire, legal, upd, eq, lts, ltu, taken, mis;
  logic unused_pc;
  assign fire  = ex_valid && !flush;
  assign legal = ex_branch_type[2] || !ex_branch_type[1];
  assign upd   = fire && legal;
  assign eq    = ex_rs1 == ex_rs2;
  assign lts   = $signed(ex_rs1) < $signed(ex_rs2);
  assign ltu   = ex_rs1 < ex_rs2;
  assign taken = (ex_branch_type == BEQ)  ? eq   :
                 (ex_branch_type == BNE)  ? !eq  :
                 (ex_branch_type == BLT)  ? lts  :
                 (ex_branch_type == BGE)  ? !lts :
                 (ex_branch_type == BLTU) ? ltu  :
                 (ex_branch_type == BGEU) ? !ltu : 1'b0;
  assign mis   = legal && (taken ^ ex_pred_taken);
  assign unused_pc = ^{if_pc, ex_pc};
`ifdef BRANCH_RESOLVE_BHT_EN
  branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[BHT_IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (upd),
    .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken (taken)
  );
`else
  assign if_pred_taken = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid       <= 1'b0;
      res_taken       <= 1'b0;
      res_mispredict  <= 1'b0;
      res_illegal     <= 1'b0;
      res_redirect_pc <= '0;
      branch_cnt      <= '0;
      mispred_cnt     <= '0;
    end else begin
      res_valid      <= fire;
      res_taken      <= upd && taken;
      res_mispredict <= fire && mis;
      res_illegal    <= fire && !legal;
      if (fire) res_redirect_pc <= (legal && taken) ? ex_pc + ex_imm : ex_pc + XLEN'(4);
      if (upd) branch_cnt <= branch_cnt + 1'b1;
      if (upd && mis) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of branch resolution, BHT training, flush, illegal and reset
module tb_branch_resolve_unit;
  import riscv_branch_pkg::*;
`ifdef BRANCH_RESOLVE_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_pred_taken, flush;
  logic [2:0]  ex_branch_type;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm, if_pc;
  logic        if_pred_taken, res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] res_redirect_pc;
  logic [3:0]  branch_cnt, mispred_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch_type(ex_branch_type),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .flush(flush), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_illegal(res_illegal),
    .res_redirect_pc(res_redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] imm, input logic p);
    ex_valid = 1'b1; ex_branch_type = t; ex_rs1 = a; ex_rs2 = b;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic res(input string tag, input logic v, input logic tk, input logic m,
                     input logic il, input logic [31:0] rpc);
    check({tag, "_valid"}, 32'(res_valid), 32'(v));
    check({tag, "_taken"}, 32'(res_taken), 32'(tk));
    check({tag, "_mispred"}, 32'(res_mispredict), 32'(m));
    check({tag, "_illegal"}, 32'(res_illegal), 32'(il));
    if (v) check({tag, "_redirect"}, res_redirect_pc, rpc);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; ex_branch_type = 3'b000;
    ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 1'b0;
    if_pc = 32'h40;
    #12;
    res("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_redirect", res_redirect_pc, 32'h0);
    check("rst_bcnt", 32'(branch_cnt), 32'd0);
    check("rst_mcnt", 32'(mispred_cnt), 32'd0);
    check("rst_pred", 32'(if_pred_taken), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(res_valid), 32'd0);

    br(BLT, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h20, 1'b0); tick();
    res("blt", 1'b1, 1'b1, 1'b1, 1'b0, 32'h220);
    br(BLTU, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h20, 1'b0); tick();
    res("bltu", 1'b1, 1'b0, 1'b0, 1'b0, 32'h204);
    br(BEQ, 32'd5, 32'd5, 32'h100, 32'hFFFFFFF0, 1'b1); tick();
    res("beq", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0F0);
    br(BGE, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h8, 1'b0); tick();
    res("bge", 1'b1, 1'b0, 1'b0, 1'b0, 32'h304);
    br(BGEU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h8, 1'b1); tick();
    res("bgeu", 1'b1, 1'b1, 1'b0, 1'b0, 32'h308);
    br(BNE, 32'd3, 32'd3, 32'h300, 32'h8, 1'b1); tick();
    res("bne", 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);
    br(BGE, 32'd7, 32'd7, 32'hFFFFFFFC, 32'h8, 1'b1); tick();
    res("wrap_pc", 1'b1, 1'b1, 1'b0, 1'b0, 32'h4);
    check("cnt_b", 32'(branch_cnt), 32'd7);
    check("cnt_m", 32'(mispred_cnt), 32'd2);

    br(BEQ, 32'd1, 32'd1, 32'h40, 32'h10, 1'b0); flush = 1'b1; tick();
    check("flush_valid", 32'(res_valid), 32'd0);
    check("flush_bcnt", 32'(branch_cnt), 32'd7);
    check("flush_pred", 32'(if_pred_taken), 32'd0);
    br(3'b010, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1); tick();
    res("illegal", 1'b1, 1'b0, 1'b0, 1'b1, 32'h44);
    check("illegal_bcnt", 32'(branch_cnt), 32'd7);
    check("illegal_mcnt", 32'(mispred_cnt), 32'd2);
    check("illegal_pred", 32'(if_pred_taken), 32'd0);

    // same-cycle reads see the pre-update counter: 01,10,11,11
    br(BEQ, 32'd9, 32'd9, 32'h40, 32'h10, 1'b0);
    check("train0_pred", 32'(if_pred_taken), 32'd0); tick();
    br(BEQ, 32'd9, 32'd9, 32'h40, 32'h10, 1'b0);
    check("train1_pred", 32'(if_pred_taken), 32'(BHT)); tick();
    br(BEQ, 32'd9, 32'd9, 32'h40, 32'h10, 1'b0);
    check("train2_pred", 32'(if_pred_taken), 32'(BHT)); tick();
    br(BEQ, 32'd9, 32'd9, 32'h40, 32'h10, 1'b0);
    check("train3_pred", 32'(if_pred_taken), 32'(BHT)); tick();
    res("train", 1'b1, 1'b1, 1'b1, 1'b0, 32'h50);
    check("train_after", 32'(if_pred_taken), 32'(BHT));
    check("train_bcnt", 32'(branch_cnt), 32'd11);
    check("train_mcnt", 32'(mispred_cnt), 32'd6);
    if_pc = 32'h44;
    #1 check("other_idx_pred", 32'(if_pred_taken), 32'd0);
    if_pc = 32'h40;

    for (int i = 0; i < 10; i++) begin
      br(BNE, 32'd1, 32'd2, 32'h80, 32'h100, 1'b0); tick();
    end
    res("mwrap", 1'b1, 1'b1, 1'b1, 1'b0, 32'h180);
    check("mwrap_mcnt", 32'(mispred_cnt), 32'd0);
    check("mwrap_bcnt", 32'(branch_cnt), 32'd5);

    br(BEQ, 32'd1, 32'd1, 32'h40, 32'h10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    res("arst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("arst_redirect", res_redirect_pc, 32'h0);
    check("arst_bcnt", 32'(branch_cnt), 32'd0);
    check("arst_mcnt", 32'(mispred_cnt), 32'd0);
    check("arst_pred", 32'(if_pred_taken), 32'd0);
    tick();
    check("arst_hold", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    br(BLTU, 32'd1, 32'd2, 32'h40, 32'h20, 1'b1);
    check("first_pre", 32'(res_valid), 32'd0); tick();
    res("first", 1'b1, 1'b1, 1'b0, 1'b0, 32'h60);
    check("first_bcnt", 32'(branch_cnt), 32'd1);
    check("first_pred", 32'(if_pred_taken), 32'(BHT));
    tick();
    check("first_drop", 32'(res_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
